disaster_alarm_controller: RTL and testbench

//  Sequences the shared alarm output stage (siren + one-hot hazard LED bank) for the warning device.

---
 rtl/disaster_pkg.sv | 24 ++
 rtl/hazard_debounce.sv | 25 ++
 rtl/disaster_alarm_controller.sv | 135 +++++++++++++
 tb/tb_disaster_alarm_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/disaster_pkg.sv
// Shared definitions for the disaster alarm controller: hazard indices,
// FSM state encoding and the fixed-priority hazard encoder.
package disaster_pkg;

  localparam logic [1:0] HZ_FLOOD   = 2'd0;
  localparam logic [1:0] HZ_CYCLONE = 2'd1;
  localparam logic [1:0] HZ_QUAKE   = 2'd2;
  localparam logic [1:0] HZ_TSUNAMI = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALERT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Lowest set index wins; an all-zero request returns HZ_TSUNAMI and must be gated by the caller.
  function automatic logic [1:0] prio_enc(input logic [3:0] req);
    if (req[0])      prio_enc = HZ_FLOOD;
    else if (req[1]) prio_enc = HZ_CYCLONE;
    else if (req[2]) prio_enc = HZ_QUAKE;
    else             prio_enc = HZ_TSUNAMI;
  endfunction

endpackage

// File: rtl/hazard_debounce.sv
// Per-flag debouncer: a raw hazard flag counts as confirmed once it has been
// high for DEBOUNCE consecutive clocks; any low clock restarts the count.
module hazard_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic confirmed
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!raw)           cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign confirmed = (cnt == CNT_MAX);

endmodule

// File: rtl/disaster_alarm_controller.sv
// Alarm output sequencer: debounces four hazard flags, latches them as pending and
// grants the siren/LED stage to one hazard at a time by fixed priority with preemption.
module disaster_alarm_controller
  import disaster_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned ALERT_CYCLES = 16,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned BLINK_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] haz_in,
  input  logic       ack,
  output logic [3:0] pending,
  output logic       alarm_active,
  output logic [1:0] alarm_code,
  output logic [3:0] led,
  output logic       siren
);

  localparam int unsigned TW = $clog2(ALERT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  localparam logic [TW-1:0] T_LAST = TW'(ALERT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [3:0] confirmed;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    hazard_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk       (clk),
      .rst       (rst),
      .raw       (haz_in[i]),
      .confirmed (confirmed[i])
    );
  end

  state_t        state, state_d;
  logic [1:0]    code, code_d;
  logic [TW-1:0] timer, timer_d;
  logic [BW-1:0] blink, blink_d;
  logic [GW-1:0] gap, gap_d;
  logic          siren_q, siren_d;
  logic [3:0]    pend_clr, pending_d;
  logic [1:0]    top;

  // Set has priority over the ack clear, so a still-present hazard stays pending.
  always_comb begin
    pend_clr = '0;
    if (state == ST_ALERT && ack) pend_clr[code] = 1'b1;
    pending_d = confirmed | (pending & ~pend_clr);
  end

  always_comb begin
    state_d = state;
    code_d  = code;
    timer_d = timer;
    blink_d = blink;
    gap_d   = gap;
    siren_d = siren_q;
    top     = prio_enc(pending);
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_d = ST_ALERT;
          code_d  = top;
          timer_d = '0;
          blink_d = '0;
          siren_d = 1'b1;
        end
      end
      ST_ALERT: begin
        // Ack is checked first so it wins over a same-cycle preempt.
        if (ack || (timer == T_LAST && !((|pending) && top < code))) begin
          state_d = ST_GAP;
          gap_d   = '0;
          timer_d = '0;
          blink_d = '0;
          siren_d = 1'b0;
        end else if ((|pending) && top < code) begin
          code_d  = top;
          timer_d = '0;
          blink_d = '0;
          siren_d = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
          if (blink == B_LAST) begin
            blink_d = '0;
            siren_d = ~siren_q;
          end else begin
            blink_d = blink + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap == G_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      code    <= '0;
      timer   <= '0;
      blink   <= '0;
      gap     <= '0;
      siren_q <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_d;
      code    <= code_d;
      timer   <= timer_d;
      blink   <= blink_d;
      gap     <= gap_d;
      siren_q <= siren_d;
      pending <= pending_d;
    end
  end

  assign alarm_active = (state == ST_ALERT);
  assign alarm_code   = alarm_active ? code : 2'd0;
  assign led          = alarm_active ? (4'b0001 << code) : 4'b0000;
  assign siren        = siren_q & alarm_active;

endmodule

// File: tb/tb_disaster_alarm_controller.sv
// Self-checking bench for disaster_alarm_controller: phase tables of
// {inputs, expected outputs} run cycle by cycle through an expectation queue.
module tb_disaster_alarm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] haz_in = '0;
  logic       ack = 1'b0;
  logic [3:0] pending;
  logic       alarm_active;
  logic [1:0] alarm_code;
  logic [3:0] led;
  logic       siren;

  disaster_alarm_controller #(
    .DEBOUNCE     (4),
    .ALERT_CYCLES (16),
    .GAP_CYCLES   (4),
    .BLINK_DIV    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .haz_in       (haz_in),
    .ack          (ack),
    .pending      (pending),
    .alarm_active (alarm_active),
    .alarm_code   (alarm_code),
    .led          (led),
    .siren        (siren)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  haz;
    logic        ack;
    int unsigned n;
    logic [3:0]  pend;
    logic        act;
    logic [1:0]  code;
    logic        sir;
  } phase_t;

  typedef struct packed {
    logic [3:0] pend;
    logic       act;
    logic [1:0] code;
    logic [3:0] led;
    logic       sir;
  } obs_t;

  phase_t plan[$];
  obs_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic phase_t ph(input logic [3:0] h, input logic a, input int unsigned n,
                                input logic [3:0] p, input logic act, input logic [1:0] c,
                                input logic s);
    phase_t r;
    r.haz = h; r.ack = a; r.n = n; r.pend = p; r.act = act; r.code = c; r.sir = s;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pend = pending; o.act = alarm_active; o.code = alarm_code; o.led = led; o.sir = siren;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got pend=%b act=%b code=%0d led=%b siren=%b, want pend=%b act=%b code=%0d led=%b siren=%b",
               name, got.pend, got.act, got.code, got.led, got.sir,
               want.pend, want.act, want.code, want.led, want.sir);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; haz_in = '0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_state", sample(), '0);
  endtask

  task automatic run_plan(input string name);
    obs_t e;
    int unsigned cyc = 0;
    foreach (plan[p]) begin
      for (int unsigned k = 0; k < plan[p].n; k++) begin
        @(negedge clk);
        haz_in = plan[p].haz;
        ack    = plan[p].ack;
        e.pend = plan[p].pend;
        e.act  = plan[p].act;
        e.code = plan[p].act ? plan[p].code : 2'd0;
        e.led  = plan[p].act ? (4'b0001 << plan[p].code) : 4'b0000;
        e.sir  = plan[p].sir;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("%s@edge%0d", name, cyc), sample(), exp_q.pop_front());
      end
    end
    plan.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset during an active alert
    do_reset();
    plan.push_back(ph(4'b0001, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0001, 1'b0, 1, 4'b0001, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0001, 1'b0, 3, 4'b0001, 1'b1, 2'd0, 1'b1));
    run_plan("rst_pre");
    #2 rst = 1'b1;
    #1 check("rst_mid_alert", sample(), '0);
    @(negedge clk);
    rst = 1'b0; haz_in = '0;
    plan.push_back(ph(4'b0000, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    run_plan("rst_post");

    // Glitch shorter than DEBOUNCE
    do_reset();
    plan.push_back(ph(4'b0010, 1'b0, 3, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0000, 1'b0, 8, 4'b0000, 1'b0, 2'd0, 1'b0));
    run_plan("glitch");

    // Basic flood alert, blink, ack, gap
    do_reset();
    plan.push_back(ph(4'b0001, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0001, 1'b0, 1, 4'b0001, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0001, 1'b0, 8, 4'b0001, 1'b1, 2'd0, 1'b1));
    plan.push_back(ph(4'b0000, 1'b0, 6, 4'b0001, 1'b1, 2'd0, 1'b0));
    plan.push_back(ph(4'b0000, 1'b1, 1, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0000, 1'b0, 6, 4'b0000, 1'b0, 2'd0, 1'b0));
    run_plan("basic");

    // Flood preempts tsunami; tsunami resumes after flood ack and gap
    do_reset();
    plan.push_back(ph(4'b1000, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1000, 1'b0, 1, 4'b1000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1000, 1'b0, 2, 4'b1000, 1'b1, 2'd3, 1'b1));
    plan.push_back(ph(4'b1001, 1'b0, 4, 4'b1000, 1'b1, 2'd3, 1'b1));
    plan.push_back(ph(4'b1001, 1'b0, 1, 4'b1001, 1'b1, 2'd3, 1'b1));
    plan.push_back(ph(4'b1001, 1'b0, 3, 4'b1001, 1'b1, 2'd0, 1'b1));
    plan.push_back(ph(4'b1000, 1'b0, 1, 4'b1001, 1'b1, 2'd0, 1'b1));
    plan.push_back(ph(4'b1000, 1'b1, 1, 4'b1000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1000, 1'b0, 4, 4'b1000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1000, 1'b0, 3, 4'b1000, 1'b1, 2'd3, 1'b1));
    run_plan("preempt");

    // Ack and preempt in the same cycle: ack wins, flood granted after the gap
    do_reset();
    plan.push_back(ph(4'b1000, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1000, 1'b0, 1, 4'b1000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1000, 1'b0, 2, 4'b1000, 1'b1, 2'd3, 1'b1));
    plan.push_back(ph(4'b1001, 1'b0, 4, 4'b1000, 1'b1, 2'd3, 1'b1));
    plan.push_back(ph(4'b1001, 1'b0, 1, 4'b1001, 1'b1, 2'd3, 1'b1));
    plan.push_back(ph(4'b1001, 1'b1, 1, 4'b1001, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1001, 1'b0, 4, 4'b1001, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b1001, 1'b0, 2, 4'b1001, 1'b1, 2'd0, 1'b1));
    run_plan("ack_vs_preempt");

    // Timeout without ack repeats the alert
    do_reset();
    plan.push_back(ph(4'b0010, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0010, 1'b0, 1, 4'b0010, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0010, 1'b0, 8, 4'b0010, 1'b1, 2'd1, 1'b1));
    plan.push_back(ph(4'b0010, 1'b0, 8, 4'b0010, 1'b1, 2'd1, 1'b0));
    plan.push_back(ph(4'b0010, 1'b0, 5, 4'b0010, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0010, 1'b0, 2, 4'b0010, 1'b1, 2'd1, 1'b1));
    run_plan("timeout");

    // Ack while the hazard is still present keeps it pending; ack ignored in GAP
    do_reset();
    plan.push_back(ph(4'b0100, 1'b0, 4, 4'b0000, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0100, 1'b0, 1, 4'b0100, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0100, 1'b0, 2, 4'b0100, 1'b1, 2'd2, 1'b1));
    plan.push_back(ph(4'b0100, 1'b1, 1, 4'b0100, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0100, 1'b1, 3, 4'b0100, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0100, 1'b0, 1, 4'b0100, 1'b0, 2'd0, 1'b0));
    plan.push_back(ph(4'b0100, 1'b0, 2, 4'b0100, 1'b1, 2'd2, 1'b1));
    run_plan("ack_held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
